// File: rtl/ram_fifo_ctrl_if.sv
// Stream, RAM and status signals of the RAM-backed FIFO controller.
// The controller connects through slave; the surrounding logic (or a bench) uses master.
interface ram_fifo_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ram_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;

  modport slave (
    input  in_data, in_valid, out_ready, ram_q,
    output in_ready, out_data, out_valid, ram_data, ram_addr, ram_we, count, full, empty
  );

  modport master (
    output in_data, in_valid, out_ready, ram_q,
    input  in_ready, out_data, out_valid, ram_data, ram_addr, ram_we, count, full, empty
  );
endinterface

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over one external single-port RAM with a registered output byte.
// Reads take priority over writes; at most one RAM operation is issued per cycle.
module ram_fifo_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  ram_fifo_ctrl_if.slave  bus
);

  localparam int unsigned   Depth     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CountFull = (ADDR_W + 1)'(Depth);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              rd_pend_q, rd_pend_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic rd_issue;
  logic in_ready;
  logic push;
  logic pop;

  // A read is launched whenever the output register is free or being freed this cycle.
  assign rd_issue = (count_q != '0) && !rd_pend_q && (!out_valid_q || bus.out_ready);
  assign in_ready = (count_q != CountFull) && !rd_issue;
  assign push     = bus.in_valid && in_ready;
  assign pop      = out_valid_q && bus.out_ready;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_pend_d   = rd_issue;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (rd_issue) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      count_d  = count_q - (ADDR_W + 1)'(1);
    end else if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      count_d  = count_q + (ADDR_W + 1)'(1);
    end

    // A load from RAM wins over a pop in the same cycle, keeping out_valid high.
    if (rd_pend_q) begin
      out_data_d  = bus.ram_q;
      out_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_pend_q   <= rd_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    bus.in_ready  = in_ready;
    bus.ram_we    = push;
    bus.ram_addr  = push ? wr_ptr_q : rd_ptr_q;
    bus.ram_data  = bus.in_data;
    bus.out_data  = out_data_q;
    bus.out_valid = out_valid_q;
    bus.count     = count_q;
    bus.full      = (count_q == CountFull);
    bus.empty     = (count_q == '0) && !rd_pend_q && !out_valid_q;
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: cycle table, fill/drain, full-then-pop, reset mid-read.
// A behavioural single-port RAM sits on the RAM side; a scoreboard checks output order.
module tb_ram_fifo_ctrl;

  logic clk = 1'b0;
  logic rst;

  ram_fifo_ctrl_if #(.DATA_W(8), .ADDR_W(6)) bus ();

  ram_fifo_ctrl #(.DATA_W(8), .ADDR_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single-port RAM: write on ram_we, else registered read of ram_addr.
  logic [7:0] mem [64];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_data;
    else            bus.ram_q <= mem[bus.ram_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: bytes queued on push accept, compared on pop; write address tracked too.
  logic [7:0] sb_q[$];
  logic [5:0] wa_exp;
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      wa_exp = '0;
    end else begin
      if (bus.full) chk("no_write_when_full", 32'(bus.ram_we), 32'(0));
      if (bus.in_valid && bus.in_ready) begin
        chk("push_we", 32'(bus.ram_we), 32'(1));
        chk("push_addr", 32'(bus.ram_addr), 32'(wa_exp));
        sb_q.push_back(bus.in_data);
        wa_exp = wa_exp + 6'd1;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) chk("pop_unexpected", 32'(1), 32'(0));
        else                  chk("pop_data", 32'(bus.out_data), 32'(sb_q.pop_front()));
      end
    end
  end

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       ir;
    logic       we;
    logic [5:0] addr;
    logic       ov;
    logic [7:0] od;
    logic [6:0] cnt;
    logic       emp;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic iv, input logic [7:0] id,
                              input logic ordy, input logic ir, input logic we,
                              input logic [5:0] addr, input logic ov, input logic [7:0] od,
                              input logic [6:0] cnt, input logic emp);
    vec_t v;
    v.rst = r;  v.iv = iv; v.id = id; v.ordy = ordy; v.ir = ir; v.we = we;
    v.addr = addr; v.ov = ov; v.od = od; v.cnt = cnt; v.emp = emp;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d);
    logic acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) chk("push_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain(input int n_exp, output logic [7:0] last_b);
    int  pops   = 0;
    int  last_c = -1;
    bit  done   = 1'b0;
    last_b = 8'h00;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (last_c >= 0) chk("pop_spacing", 32'(c - last_c), 32'(2));
        last_c = c;
        pops++;
        last_b = bus.out_data;
      end
      if (bus.empty) done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b0;
    chk("drain_count", 32'(pops), 32'(n_exp));
    chk("drain_empty", 32'(bus.empty), 32'(1));
    chk("sb_left", 32'(sb_q.size()), 32'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  vec_t       tbl[17];
  logic [7:0] last_b;

  initial begin
    bus.in_data   = 8'h00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    do_reset();

    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'(1));
    chk("rst_ram_we", 32'(bus.ram_we), 32'(0));
    chk("rst_full", 32'(bus.full), 32'(0));
    chk("rst_empty", 32'(bus.empty), 32'(1));
    chk("rst_count", 32'(bus.count), 32'(0));
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    @(posedge clk);
    #1;

    //            rst iv  id    or  ir  we addr ov od     cnt emp
    // single byte
    tbl[0]  = mk(0, 1, 8'hA5, 0,  1, 1, 6'd0, 0, 8'h00, 7'd0, 1);
    tbl[1]  = mk(0, 0, 8'h00, 0,  0, 0, 6'd0, 0, 8'h00, 7'd1, 0);
    tbl[2]  = mk(0, 0, 8'h00, 0,  1, 0, 6'd1, 0, 8'h00, 7'd0, 0);
    tbl[3]  = mk(0, 0, 8'h00, 0,  1, 0, 6'd1, 1, 8'hA5, 7'd0, 0);
    tbl[4]  = mk(0, 0, 8'h00, 1,  1, 0, 6'd1, 1, 8'hA5, 7'd0, 0);
    tbl[5]  = mk(0, 0, 8'h00, 0,  1, 0, 6'd1, 0, 8'hA5, 7'd0, 1);
    // read priority over a waiting push
    tbl[6]  = mk(0, 1, 8'h3C, 0,  1, 1, 6'd1, 0, 8'hA5, 7'd0, 1);
    tbl[7]  = mk(0, 1, 8'h5A, 0,  0, 0, 6'd1, 0, 8'hA5, 7'd1, 0);
    tbl[8]  = mk(0, 1, 8'h5A, 0,  1, 1, 6'd2, 0, 8'hA5, 7'd0, 0);
    tbl[9]  = mk(0, 0, 8'h00, 0,  1, 0, 6'd2, 1, 8'h3C, 7'd1, 0);
    tbl[10] = mk(0, 0, 8'h00, 1,  0, 0, 6'd2, 1, 8'h3C, 7'd1, 0);
    tbl[11] = mk(0, 0, 8'h00, 1,  1, 0, 6'd3, 0, 8'h3C, 7'd0, 0);
    tbl[12] = mk(0, 0, 8'h00, 0,  1, 0, 6'd3, 1, 8'h5A, 7'd0, 0);
    // reset while a read is in flight
    tbl[13] = mk(0, 1, 8'h11, 0,  1, 1, 6'd3, 1, 8'h5A, 7'd0, 0);
    tbl[14] = mk(0, 0, 8'h00, 1,  0, 0, 6'd3, 1, 8'h5A, 7'd1, 0);
    tbl[15] = mk(1, 0, 8'h00, 0,  1, 0, 6'd4, 0, 8'h5A, 7'd0, 0);
    tbl[16] = mk(0, 0, 8'h00, 0,  1, 0, 6'd0, 0, 8'h00, 7'd0, 1);

    foreach (tbl[i]) begin
      rst           = tbl[i].rst;
      bus.in_valid  = tbl[i].iv;
      bus.in_data   = tbl[i].id;
      bus.out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(tbl[i].ir));
      chk($sformatf("v%0d_ram_we", i), 32'(bus.ram_we), 32'(tbl[i].we));
      chk($sformatf("v%0d_ram_addr", i), 32'(bus.ram_addr), 32'(tbl[i].addr));
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ov));
      chk($sformatf("v%0d_out_data", i), 32'(bus.out_data), 32'(tbl[i].od));
      chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_empty", i), 32'(bus.empty), 32'(tbl[i].emp));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    // Fill: one byte sits in the output register, so 64 pushes leave 63 in RAM.
    do_reset();
    for (int i = 0; i < 64; i++) push_byte(8'(i));
    chk("fill_count63", 32'(bus.count), 32'(63));
    chk("fill_out_valid", 32'(bus.out_valid), 32'(1));
    chk("fill_out_data", 32'(bus.out_data), 32'(8'h00));
    chk("fill_not_full", 32'(bus.full), 32'(0));
    push_byte(8'h40);
    chk("fill_count64", 32'(bus.count), 32'(64));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h41;
    repeat (3) begin
      @(negedge clk);
      chk("full_flag", 32'(bus.full), 32'(1));
      chk("full_in_ready", 32'(bus.in_ready), 32'(0));
      chk("full_ram_we", 32'(bus.ram_we), 32'(0));
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    drain(65, last_b);
    chk("drain_last", 32'(last_b), 32'(8'h40));

    // Full, pop one, then push into the slot just read.
    do_reset();
    for (int i = 0; i < 65; i++) push_byte(8'(8'h80 + i));
    chk("ftp_full", 32'(bus.full), 32'(1));
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("ftp_pop_valid", 32'(bus.out_valid), 32'(1));
    chk("ftp_pop_data", 32'(bus.out_data), 32'(8'h80));
    chk("ftp_pop_in_ready", 32'(bus.in_ready), 32'(0));
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h77;
    @(negedge clk);
    chk("ftp_push_ready", 32'(bus.in_ready), 32'(1));
    chk("ftp_push_we", 32'(bus.ram_we), 32'(1));
    chk("ftp_push_addr", 32'(bus.ram_addr), 32'(1));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("ftp_old_byte", 32'(bus.out_data), 32'(8'h81));
    @(posedge clk);
    #1;
    drain(65, last_b);
    chk("ftp_last", 32'(last_b), 32'(8'h77));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
